// File: rtl/div_unit.sv
// div_unit: iterative RV32M divider for DIV, DIVU, REM and REMU.
// It performs a restoring divide that retires one quotient bit per cycle.
// Divide-by-zero and signed-overflow operands finish in a single cycle.
//
// Ports:
//   clk_i     clock; all state updates on the rising edge
//   rst_n_i   asynchronous active-low reset
//   start_i   request, sampled only in IDLE together with op_i, a_i and b_i
//   op_i      operation select: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   a_i       dividend (rs1)
//   b_i       divisor (rs2)
//   kill_i    pipeline flush; aborts an operation in CALC or FIX
//   busy_o    high in every state except IDLE
//   done_o    one-cycle pulse; result_o is valid while it is high
//   result_o  registered quotient or remainder, held until the next completion
module div_unit (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        kill_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] result_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  state;
    logic [1:0]  op_q;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [5:0]  cnt;
    logic        neg_q;
    logic        neg_r;

    logic        is_signed;
    logic        b_zero;
    logic        ovf;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [32:0] rem_shift;
    logic [32:0] rem_diff;
    logic        fits;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    always_comb begin
        is_signed = ~op_i[0];
        b_zero    = (b_i == '0);
        ovf       = is_signed && (a_i == 32'h8000_0000) && (b_i == '1);
        abs_a     = (is_signed && a_i[31]) ? (32'd0 - a_i) : a_i;
        abs_b     = (is_signed && b_i[31]) ? (32'd0 - b_i) : b_i;
        // The partial remainder is always below the divisor, so the 33-bit
        // trial value stays below twice the divisor. Bit 32 of the difference
        // is therefore set only on a borrow, and the 33rd register bit is
        // never needed after the subtraction.
        rem_shift = {rem, dvd[31]};
        rem_diff  = rem_shift - {1'b0, dvs};
        fits      = ~rem_diff[32];
        quot_fix  = neg_q ? (32'd0 - quot) : quot;
        rem_fix   = neg_r ? (32'd0 - rem)  : rem;
    end

    assign busy_o = (state != S_IDLE);
    assign done_o = (state == S_DONE);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state    <= S_IDLE;
            op_q     <= '0;
            dvd      <= '0;
            dvs      <= '0;
            quot     <= '0;
            rem      <= '0;
            cnt      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i && !kill_i) begin
                        op_q <= op_i;
                        if (b_zero) begin
                            result_o <= op_i[1] ? a_i : '1;
                            state    <= S_DONE;
                        end else if (ovf) begin
                            result_o <= op_i[1] ? 32'd0 : 32'h8000_0000;
                            state    <= S_DONE;
                        end else begin
                            dvd   <= abs_a;
                            dvs   <= abs_b;
                            neg_q <= is_signed & (a_i[31] ^ b_i[31]);
                            neg_r <= is_signed & a_i[31];
                            rem   <= '0;
                            quot  <= '0;
                            cnt   <= '0;
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (kill_i) begin
                        state <= S_IDLE;
                    end else begin
                        dvd  <= {dvd[30:0], 1'b0};
                        rem  <= fits ? rem_diff[31:0] : rem_shift[31:0];
                        quot <= {quot[30:0], fits};
                        cnt  <= cnt + 6'd1;
                        if (cnt == 6'd31) begin
                            state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (kill_i) begin
                        state <= S_IDLE;
                    end else begin
                        result_o <= op_q[1] ? rem_fix : quot_fix;
                        state    <= S_DONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed testbench for div_unit.
// A latency/result model derived from the architectural rules runs beside the DUT.
// A compare process checks busy_o, done_o and result_o against that model on
// every falling edge. Directed sequences also check literal results and latencies.
module tb_div_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        kill;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int unsigned total_checks;
    int unsigned pass_checks;
    logic        cmp_en;

    div_unit dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .start_i  (start),
        .op_i     (op),
        .a_i      (a),
        .b_i      (b),
        .kill_i   (kill),
        .busy_o   (busy),
        .done_o   (done),
        .result_o (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act === exp) begin
            pass_checks++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result: truncating division, remainder takes the dividend's sign.
    function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] x,
                                               input logic [31:0] y);
        logic signed [31:0] sx;
        logic signed [31:0] sy;
        sx = x;
        sy = y;
        if (y == 0) return o[1] ? x : 32'hFFFF_FFFF;
        if (!o[0]) begin
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
            return o[1] ? 32'(sx % sy) : 32'(sx / sy);
        end
        return o[1] ? (x % y) : (x / y);
    endfunction

    function automatic bit is_special(input logic [1:0] o, input logic [31:0] x,
                                      input logic [31:0] y);
        return (y == 0) || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
    endfunction

    // Model: m_left counts the edges remaining until the unit is idle again.
    // done is visible in the final cycle, and the result commits on entry to it.
    int          m_left;
    logic [31:0] m_pending;
    logic [31:0] m_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_res  <= '0;
        end else if (m_left == 0) begin
            if (start && !kill) begin
                if (is_special(op, a, b)) begin
                    m_left <= 1;
                    m_res  <= ref_result(op, a, b);
                end else begin
                    m_left    <= 34;
                    m_pending <= ref_result(op, a, b);
                end
            end
        end else if (kill && m_left > 1) begin
            m_left <= 0;
        end else begin
            m_left <= m_left - 1;
            if (m_left == 2) m_res <= m_pending;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model busy", {31'd0, busy}, {31'd0, m_left > 0});
            check("model done", {31'd0, done}, {31'd0, m_left == 1});
            check("model result", result, m_res);
        end
    end

    // Runs one operation. exp_edge is the edge index (edge 0 samples start)
    // after which done_o must be seen. inject_k >= 0 pulses a stray start at that cycle.
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp, input int exp_edge,
                          input int inject_k);
        int k;
        bit got;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        k = 0;
        got = 1'b0;
        while (k < 100) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (k == inject_k) begin
                start = 1'b1; op = 2'b01; a = 32'd5; b = 32'd1;
            end else begin
                start = 1'b0;
            end
            k++;
            @(negedge clk);
        end
        start = 1'b0;
        check({name, " done seen"}, {31'd0, got}, 32'd1);
        check({name, " latency"}, k, exp_edge);
        check({name, " result"}, result, exp);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bit seen;
        total_checks = 0;
        pass_checks  = 0;
        cmp_en = 1'b0;
        rst_n = 1'b0; start = 1'b0; kill = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);
        cmp_en = 1'b1;

        run_op("divu 100/7", 2'b01, 32'd100, 32'd7, 32'd14, 33, -1);
        run_op("remu 100/7", 2'b11, 32'd100, 32'd7, 32'd2, 33, -1);
        run_op("div -7/2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, -1);
        run_op("rem -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, -1);
        run_op("div 7/-2", 2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, -1);
        run_op("rem 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, -1);
        run_op("div by 0", 2'b00, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 0, -1);
        run_op("remu by 0", 2'b11, 32'h1234_5678, 32'd0, 32'h1234_5678, 0, -1);
        run_op("div ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, -1);
        run_op("rem ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, -1);
        run_op("div min/2", 2'b00, 32'h8000_0000, 32'd2, 32'hC000_0000, 33, -1);
        run_op("divu max/1", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, -1);
        run_op("remu 5/max", 2'b11, 32'd5, 32'hFFFF_FFFF, 32'd5, 33, -1);
        run_op("divu stray start", 2'b01, 32'd100, 32'd7, 32'd14, 33, 10);

        // Kill during CALC: back to idle, no done, result unchanged.
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'd100; b = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 15; i++) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill busy", {31'd0, busy}, 32'd0);
        check("kill result kept", result, 32'd14);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("kill no done", {31'd0, seen}, 32'd0);

        // Asynchronous reset mid-operation.
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'd1000; b = 32'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20; i++) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort result", result, 32'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("abort no done", {31'd0, seen}, 32'd0);

        run_op("divu 9/3", 2'b01, 32'd9, 32'd3, 32'd3, 33, -1);

        repeat (3) @(negedge clk);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", pass_checks, total_checks);
        $finish;
    end

endmodule
